// File: rtl/sppm_pkg.sv
// Shared constants and types for the multi-channel SPPM coincidence binner.
package sppm_pkg;
  localparam int NCH_MAX    = 8;
  localparam int NBINS_MIN  = 4;
  localparam int NBINS_MAX  = 512;
  localparam int WIN_MAX    = 8;
  localparam int HCNT_W     = 10;
  localparam int SPPM_EDGE  = 1;
  localparam int SPPM_LEVEL = 0;

  typedef enum logic {ST_IDLE = 1'b0, ST_READ = 1'b1} sppm_state_e;

  function automatic bit sppm_cfg_ok(int nch, int nbins, int win, int mode);
    return nch >= 1 && nch <= NCH_MAX && nbins >= NBINS_MIN && nbins <= NBINS_MAX &&
           win >= 1 && win <= WIN_MAX && (mode == SPPM_EDGE || mode == SPPM_LEVEL);
  endfunction
endpackage

// File: rtl/sppm_bin_chan.sv
// One detector channel: capture vector, hit extraction on hand-over, popcount and
// the forward window OR for the next readout beat.
module sppm_bin_chan
  import sppm_pkg::*;
#(
  parameter int NBINS     = 101,
  parameter int WIN       = 3,
  parameter int EDGE_MODE = SPPM_EDGE,
  parameter int FILL_W    = 7,
  parameter int IDX_W     = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              smp_en,
  input  logic [FILL_W-1:0] fill,
  input  logic              din,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  output logic              win,
  output logic [HCNT_W-1:0] cnt
);
  localparam logic [NBINS-1:0] ONE   = NBINS'(1);
  // Window mask saturates to all ones if WIN exceeds the frame length.
  localparam logic [NBINS-1:0] WMASK = (ONE << WIN) - ONE;

  logic [NBINS-1:0]  cap, rd, rd_next, src, samp;
  logic [HCNT_W-1:0] cnt_next;

  assign samp = din ? (ONE << fill) : '0;

  if (EDGE_MODE == SPPM_LEVEL) begin : g_level
    assign rd_next = cap;
  end else begin : g_edge
    // Shift in a 1 below bin 0 so the first bin can never register an edge.
    assign rd_next = cap & ~{cap[NBINS-2:0], 1'b1};
  end

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < NBINS; k++) cnt_next = cnt_next + HCNT_W'(rd_next[k]);
  end

  // On hand-over the readout register is loaded this same edge, so beat 0
  // is windowed straight from the freshly extracted hits.
  assign src = load ? rd_next : rd;
  assign win = |((src >> idx) & WMASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (start)       cap <= NBINS'(din);
      else if (smp_en) cap <= cap | samp;
      if (load) begin
        rd  <= rd_next;
        cnt <= cnt_next;
      end
    end
  end
endmodule

// File: rtl/sppm_coinc_binner.sv
// Multi-channel SPPM frame binner: per-channel capture, hand-over on syn, windowed
// readout stream with cross-channel coincidence and per-frame hit counts.
module sppm_coinc_binner
  import sppm_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int NBINS     = 101,
  parameter int WIN       = 3,
  parameter int EDGE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       syn,
  input  logic [NCH-1:0]             in,
  output logic                       out_valid,
  output logic [$clog2(NBINS)-1:0]   bin_idx,
  output logic [NCH-1:0]             out_hit,
  output logic                       out_coin,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [NCH*HCNT_W-1:0]      hit_cnt
);
  localparam int IDX_W  = $clog2(NBINS);
  localparam int FILL_W = $clog2(NBINS + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NBINS);
  localparam logic [IDX_W-1:0]  LAST_BIN  = IDX_W'(NBINS - 1);

  if (!sppm_cfg_ok(NCH, NBINS, WIN, EDGE_MODE)) begin : g_cfg_bad
    $error("sppm_coinc_binner: parameter out of range");
  end

  sppm_state_e               state;
  logic                      syn_q, have_frame;
  logic                      handover, smp_en, rd_busy, show;
  logic [FILL_W-1:0]         fill;
  logic [IDX_W-1:0]          idx_inc, win_idx;
  logic [NCH-1:0]            win;
  logic [NCH-1:0][HCNT_W-1:0] cnt;

  // syn is registered first: the sample taken on the syn edge still belongs
  // to the closing frame, and the new frame's bin 0 lands one edge later.
  assign handover = syn_q & have_frame;
  assign smp_en   = (fill != FILL_FULL);
  assign rd_busy  = (state == ST_READ) && (bin_idx != LAST_BIN);
  assign show     = handover | rd_busy;
  assign idx_inc  = bin_idx + 1'b1;
  assign win_idx  = handover ? '0 : idx_inc;
  assign hit_cnt  = cnt;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sppm_bin_chan #(
      .NBINS(NBINS), .WIN(WIN), .EDGE_MODE(EDGE_MODE), .FILL_W(FILL_W), .IDX_W(IDX_W)
    ) u_chan (
      .clk(clk), .rst_n(rst_n), .start(syn_q), .smp_en(smp_en), .fill(fill),
      .din(in[c]), .load(handover), .idx(win_idx), .win(win[c]), .cnt(cnt[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      syn_q      <= 1'b0;
      have_frame <= 1'b0;
      fill       <= '0;
      out_valid  <= 1'b0;
      bin_idx    <= '0;
      out_hit    <= '0;
      out_coin   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      syn_q    <= syn;
      out_hit  <= show ? win : '0;
      out_coin <= show & (&win);
      // A readout showing its last beat is complete, so only earlier beats count as aborted.
      overrun  <= handover & (smp_en | rd_busy);

      if (syn_q) begin
        fill       <= FILL_W'(1);
        have_frame <= 1'b1;
      end else if (smp_en) begin
        fill <= fill + 1'b1;
      end

      if (handover) begin
        state      <= ST_READ;
        out_valid  <= 1'b1;
        bin_idx    <= '0;
        frame_done <= 1'b0;
      end else if (rd_busy) begin
        out_valid  <= 1'b1;
        bin_idx    <= idx_inc;
        frame_done <= (idx_inc == LAST_BIN);
      end else begin
        state      <= ST_IDLE;
        out_valid  <= 1'b0;
        bin_idx    <= '0;
        frame_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sppm_coinc_binner.sv
// Bench for sppm_coinc_binner: edge- and level-mode instances on shared stimulus,
// a frame-level reference model checked every cycle, plus directed frame tables.
module tb_sppm_coinc_binner;
  localparam int NCH = 2, NBINS = 101, WIN = 3, IW = $clog2(NBINS);

  logic clk = 1'b0, rst_n = 1'b0, syn = 1'b0;
  logic [NCH-1:0] in_v = '0;

  logic ov_e, coin_e, fd_e, ovr_e, ov_l, coin_l, fd_l, ovr_l;
  logic [IW-1:0] idx_e, idx_l;
  logic [NCH-1:0] hit_e, hit_l;
  logic [NCH*10-1:0] cnt_e, cnt_l;

  sppm_coinc_binner #(.NCH(NCH), .NBINS(NBINS), .WIN(WIN), .EDGE_MODE(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .syn(syn), .in(in_v), .out_valid(ov_e), .bin_idx(idx_e),
    .out_hit(hit_e), .out_coin(coin_e), .frame_done(fd_e), .overrun(ovr_e), .hit_cnt(cnt_e));
  sppm_coinc_binner #(.NCH(NCH), .NBINS(NBINS), .WIN(WIN), .EDGE_MODE(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .syn(syn), .in(in_v), .out_valid(ov_l), .bin_idx(idx_l),
    .out_hit(hit_l), .out_coin(coin_l), .frame_done(fd_l), .overrun(ovr_l), .hit_cnt(cnt_l));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: frames as sample lists, readout as a beat cursor.
  bit smp [NCH][NBINS];
  bit rde [NCH][NBINS];
  bit rdl [NCH][NBINS];
  int cnte [NCH];
  int cntl [NCH];
  int nsmp, beat;
  bit have, syn_prev, ovr;

  typedef struct {
    int c0_lo, c0_hi, c1_lo, c1_hi;
    int e_cnt0, e_cnt1, e_first0, e_last0, e_n0, e_ncoin, e_fcoin;
    int l_cnt0, l_n0, l_first0;
  } vec_t;
  localparam int NV = 5;
  vec_t vecs [NV];

  int s_valid, s_first0, s_last0, s_n0, s_ncoin, s_fcoin, s_fd_n, s_fd_bin, s_ovr_n;
  int s_cnt0_e, s_cnt1_e, s_cnt0_l, s_l_n0, s_l_first0, s_l_last0, s_cnt_nz;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      cnte[c] = 0; cntl[c] = 0;
      for (int k = 0; k < NBINS; k++) begin smp[c][k] = 0; rde[c][k] = 0; rdl[c][k] = 0; end
    end
    nsmp = 0; beat = -1; have = 0; syn_prev = 0; ovr = 0;
  endtask

  task automatic model_edge(input bit s, input logic [NCH-1:0] d);
    ovr = 0;
    if (syn_prev) begin
      if (have) begin
        ovr = (nsmp < NBINS) || (beat >= 0 && beat != NBINS - 1);
        for (int c = 0; c < NCH; c++) begin
          cnte[c] = 0; cntl[c] = 0;
          for (int k = 0; k < NBINS; k++) begin
            rdl[c][k] = smp[c][k];
            rde[c][k] = (k > 0) && smp[c][k] && !smp[c][k-1];
            cnte[c] += int'(rde[c][k]);
            cntl[c] += int'(rdl[c][k]);
          end
        end
        beat = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NBINS; k++) smp[c][k] = 0;
        smp[c][0] = d[c];
      end
      nsmp = 1; have = 1;
    end else begin
      if (nsmp < NBINS) begin
        for (int c = 0; c < NCH; c++) smp[c][nsmp] = d[c];
        nsmp++;
      end
      if (beat >= 0) beat = (beat == NBINS - 1) ? -1 : beat + 1;
    end
    syn_prev = s;
  endtask

  function automatic bit win_or(bit lvl, int c);
    bit r = 0;
    for (int j = 0; j < WIN; j++)
      if (beat + j < NBINS) r = r | (lvl ? rdl[c][beat+j] : rde[c][beat+j]);
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [NCH-1:0] eh, lh;
    logic [NCH*10-1:0] ec, lc;
    bit v;
    v = (beat >= 0);
    for (int c = 0; c < NCH; c++) begin
      eh[c] = v && win_or(1'b0, c);
      lh[c] = v && win_or(1'b1, c);
      ec[c*10 +: 10] = 10'(cnte[c]);
      lc[c*10 +: 10] = 10'(cntl[c]);
    end
    chk({tag, ".e.valid"}, int'(ov_e), int'(v));
    chk({tag, ".e.bin_idx"}, int'(idx_e), v ? beat : 0);
    chk({tag, ".e.out_hit"}, int'(hit_e), int'(eh));
    chk({tag, ".e.out_coin"}, int'(coin_e), int'(v && (&eh)));
    chk({tag, ".e.frame_done"}, int'(fd_e), int'(beat == NBINS - 1));
    chk({tag, ".e.overrun"}, int'(ovr_e), int'(ovr));
    chk({tag, ".e.hit_cnt"}, int'(cnt_e), int'(ec));
    chk({tag, ".l.valid"}, int'(ov_l), int'(v));
    chk({tag, ".l.bin_idx"}, int'(idx_l), v ? beat : 0);
    chk({tag, ".l.out_hit"}, int'(hit_l), int'(lh));
    chk({tag, ".l.out_coin"}, int'(coin_l), int'(v && (&lh)));
    chk({tag, ".l.frame_done"}, int'(fd_l), int'(beat == NBINS - 1));
    chk({tag, ".l.overrun"}, int'(ovr_l), int'(ovr));
    chk({tag, ".l.hit_cnt"}, int'(cnt_l), int'(lc));
  endtask

  task automatic clr_stats();
    s_valid = 0; s_first0 = -1; s_last0 = -1; s_n0 = 0; s_ncoin = 0; s_fcoin = -1;
    s_fd_n = 0; s_fd_bin = -1; s_ovr_n = 0; s_cnt0_e = -1; s_cnt1_e = -1; s_cnt0_l = -1;
    s_l_n0 = 0; s_l_first0 = -1; s_l_last0 = -1; s_cnt_nz = 0;
  endtask

  task automatic collect();
    if (ov_e) begin
      s_valid++;
      s_cnt0_e = int'(cnt_e[9:0]); s_cnt1_e = int'(cnt_e[19:10]); s_cnt0_l = int'(cnt_l[9:0]);
      if (hit_e[0]) begin if (s_first0 < 0) s_first0 = int'(idx_e); s_last0 = int'(idx_e); s_n0++; end
      if (coin_e) begin if (s_fcoin < 0) s_fcoin = int'(idx_e); s_ncoin++; end
    end
    if (ov_l && hit_l[0]) begin
      if (s_l_first0 < 0) s_l_first0 = int'(idx_l);
      s_l_last0 = int'(idx_l); s_l_n0++;
    end
    if (fd_e) begin s_fd_n++; s_fd_bin = int'(idx_e); end
    if (ovr_e) s_ovr_n++;
    if (cnt_e != '0 || cnt_l != '0) s_cnt_nz++;
  endtask

  task automatic step(input logic s, input logic [NCH-1:0] d);
    @(negedge clk);
    syn = s; in_v = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
    check_all("cyc");
    collect();
  endtask

  task automatic do_reset();
    @(negedge clk);
    syn = 1'b0; in_v = '0; rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit lvl(int lo, int hi, int k);
    return lo >= 0 && k >= lo && k <= hi;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //          c0_lo c0_hi c1_lo c1_hi | cnt0 cnt1 f0  l0 n0 ncoin fcoin | lcnt0 ln0 lf0
    vecs[0] = '{10,  19,   -1,  -1,     1,   0,   8,  10, 3, 0,    -1,     10,   12, 8};
    vecs[1] = '{40,  45,   42,  50,     1,   1,   38, 40, 3, 1,    40,     6,    8,  38};
    vecs[2] = '{40,  45,   43,  50,     1,   1,   38, 40, 3, 0,    -1,     6,    8,  38};
    vecs[3] = '{100, 100,  -1,  -1,     1,   0,   98, 100,3, 0,    -1,     1,    3,  98};
    vecs[4] = '{0,   2,    -1,  -1,     0,   0,   -1, -1, 0, 0,    -1,     3,    3,  0};

    model_reset();
    #1;
    check_all("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back full frames, each readout checked against the table record.
    for (int i = 0; i <= NV; i++) begin
      clr_stats();
      step(1'b1, '0);
      for (int k = 0; k < NBINS; k++) begin
        logic [NCH-1:0] d;
        d = '0;
        if (i < NV) d = {lvl(vecs[i].c1_lo, vecs[i].c1_hi, k), lvl(vecs[i].c0_lo, vecs[i].c0_hi, k)};
        step(1'b0, d);
      end
      if (i == 0) begin
        chk("first.no_readout", s_valid, 0);
        chk("first.hit_cnt_zero", s_cnt_nz, 0);
      end else begin
        v = vecs[i-1];
        chk($sformatf("v%0d.e_cnt0", i-1), s_cnt0_e, v.e_cnt0);
        chk($sformatf("v%0d.e_cnt1", i-1), s_cnt1_e, v.e_cnt1);
        chk($sformatf("v%0d.e_first0", i-1), s_first0, v.e_first0);
        chk($sformatf("v%0d.e_last0", i-1), s_last0, v.e_last0);
        chk($sformatf("v%0d.e_n0", i-1), s_n0, v.e_n0);
        chk($sformatf("v%0d.e_ncoin", i-1), s_ncoin, v.e_ncoin);
        chk($sformatf("v%0d.e_fcoin", i-1), s_fcoin, v.e_fcoin);
        chk($sformatf("v%0d.l_cnt0", i-1), s_cnt0_l, v.l_cnt0);
        chk($sformatf("v%0d.l_n0", i-1), s_l_n0, v.l_n0);
        chk($sformatf("v%0d.l_first0", i-1), s_l_first0, v.l_first0);
        chk($sformatf("v%0d.beats", i-1), s_valid, NBINS);
        chk($sformatf("v%0d.fd_n", i-1), s_fd_n, 1);
        chk($sformatf("v%0d.fd_bin", i-1), s_fd_bin, NBINS - 1);
        chk($sformatf("v%0d.no_ovr", i-1), s_ovr_n, 0);
      end
    end

    // Short frame: second syn 50 cycles after the first, ch0 high from bin 45.
    begin
      int o1;
      clr_stats();
      step(1'b1, '0);
      for (int j = 1; j < 50; j++) step(1'b0, {1'b0, (j - 1) >= 45});
      step(1'b1, 2'b01);
      chk("ovr.no_done_aborted", s_fd_n, 0);
      step(1'b0, '0);
      chk("ovr.pulse", int'(ovr_e), 1);
      chk("ovr.restart_idx", int'(idx_e), 0);
      chk("ovr.restart_valid", int'(ov_e), 1);
      o1 = s_ovr_n;
      clr_stats();
      for (int k = 0; k < NBINS + 3; k++) step(1'b0, '0);
      chk("ovr.once", o1 + s_ovr_n, 1);
      chk("ovr.fd_n", s_fd_n, 1);
      chk("ovr.l_cnt0", s_cnt0_l, 5);
      chk("ovr.l_first0", s_l_first0, 43);
      chk("ovr.l_last0", s_l_last0, 49);
      chk("ovr.e_cnt0", s_cnt0_e, 1);
      chk("ovr.e_last0", s_last0, 45);
    end

    // syn held high: one-sample frames every cycle.
    for (int j = 0; j < 6; j++) step(1'b1, NCH'($urandom));
    for (int j = 0; j < 4; j++) step(1'b0, NCH'($urandom));

    // Random syn spacing (short and long frames) with random detector levels.
    for (int j = 0; j < 2500; j++) step($urandom_range(0, 69) == 0, NCH'($urandom));

    // Reset in the middle of a readout discards both frames.
    step(1'b1, '0);
    for (int j = 0; j < 30; j++) step(1'b0, NCH'($urandom));
    do_reset();
    for (int f = 0; f < 2; f++) begin
      step(1'b1, NCH'($urandom));
      for (int j = 0; j < NBINS + 5; j++) step(1'b0, NCH'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
